// File: rtl/br_resolve_queue.sv
// In-order queue of branch prediction snapshots, checked against WB resolution.
// Raises redirect/flush on mispredict, drives predictor update strobe and statistics.
module br_resolve_queue #(
  parameter int DEPTH          = 4,
  parameter int HIST_W         = 3,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_push,
  input  logic [15:0]       if_pc,
  input  logic              if_pred_taken,
  input  logic [15:0]       if_pred_target,
  input  logic [HIST_W-1:0] if_hist,
  input  logic              wb_resolve,
  input  logic              wb_actual_taken,
  input  logic [15:0]       wb_actual_target,
  output logic              full,
  output logic              empty,
  output logic              redirect_valid,
  output logic [15:0]       redirect_pc,
  output logic              upd_valid,
  output logic [15:0]       upd_pc,
  output logic [HIST_W-1:0] upd_hist,
  output logic              upd_taken,
  output logic [15:0]       br_count,
  output logic [15:0]       mp_count,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (RECOVER_CYCLES < 1) ? 1 : $clog2(RECOVER_CYCLES + 1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] REC_LOAD = CW'(RECOVER_CYCLES);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     rec_cnt, rec_cnt_next;
  logic [AW:0]       wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;

  logic [15:0]       pc_mem     [DEPTH];
  logic [15:0]       tgt_mem    [DEPTH];
  logic              taken_mem  [DEPTH];
  logic [HIST_W-1:0] hist_mem   [DEPTH];

  logic              ptr_full, ptr_empty, in_run;
  logic [15:0]       h_pc, h_tgt;
  logic              h_taken;
  logic [HIST_W-1:0] h_hist;
  logic              do_pop, do_push, mispredict, err_set;
  logic [15:0]       redirect_calc;

  assign ptr_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign ptr_empty = (wr_ptr == rd_ptr);
  assign in_run    = (state == RUN);

  assign h_pc    = pc_mem[rd_ptr[AW-1:0]];
  assign h_tgt   = tgt_mem[rd_ptr[AW-1:0]];
  assign h_taken = taken_mem[rd_ptr[AW-1:0]];
  assign h_hist  = hist_mem[rd_ptr[AW-1:0]];

  // Resolve/push qualification, squash and error detection
  always_comb begin
    do_pop     = wb_resolve & in_run & ~ptr_empty;
    mispredict = do_pop & ((h_taken != wb_actual_taken) |
                           (h_taken & wb_actual_taken & (h_tgt != wb_actual_target)));
    // a younger-path push alongside a mispredict is dropped without error
    do_push    = if_push & in_run & ~ptr_full & ~mispredict;
    err_set    = (if_push & in_run & ptr_full & ~mispredict) |
                 (wb_resolve & (~in_run | ptr_empty));
    redirect_calc = wb_actual_taken ? wb_actual_target : (h_pc + 16'd2);
    rd_ptr_next = do_pop ? (rd_ptr + PTR_ONE) : rd_ptr;
    if (mispredict) begin
      wr_ptr_next = rd_ptr_next;
    end else if (do_push) begin
      wr_ptr_next = wr_ptr + PTR_ONE;
    end else begin
      wr_ptr_next = wr_ptr;
    end
  end

  // Recovery FSM next-state logic
  always_comb begin
    state_next   = state;
    rec_cnt_next = rec_cnt;
    case (state)
      RUN: begin
        if (mispredict) begin
          state_next   = RECOVER;
          rec_cnt_next = REC_LOAD;
        end else begin
          state_next   = RUN;
        end
      end
      RECOVER: begin
        if (rec_cnt <= {{(CW-1){1'b0}}, 1'b1}) begin
          state_next   = RUN;
          rec_cnt_next = {CW{1'b0}};
        end else begin
          rec_cnt_next = rec_cnt - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_next   = RUN;
        rec_cnt_next = {CW{1'b0}};
      end
    endcase
  end

  // Snapshot storage; entries need no reset, pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr[AW-1:0]]    <= if_pc;
      tgt_mem[wr_ptr[AW-1:0]]   <= if_pred_target;
      taken_mem[wr_ptr[AW-1:0]] <= if_pred_taken;
      hist_mem[wr_ptr[AW-1:0]]  <= if_hist;
    end
  end

  // Control state, status flags, strobes, payloads and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      rec_cnt        <= {CW{1'b0}};
      wr_ptr         <= {(AW+1){1'b0}};
      rd_ptr         <= {(AW+1){1'b0}};
      full           <= 1'b0;
      empty          <= 1'b1;
      redirect_valid <= 1'b0;
      redirect_pc    <= 16'h0000;
      upd_valid      <= 1'b0;
      upd_pc         <= 16'h0000;
      upd_hist       <= {HIST_W{1'b0}};
      upd_taken      <= 1'b0;
      br_count       <= 16'h0000;
      mp_count       <= 16'h0000;
      err            <= 1'b0;
    end else begin
      state          <= state_next;
      rec_cnt        <= rec_cnt_next;
      wr_ptr         <= wr_ptr_next;
      rd_ptr         <= rd_ptr_next;
      full           <= (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]) &&
                        (wr_ptr_next[AW] != rd_ptr_next[AW]);
      empty          <= (wr_ptr_next == rd_ptr_next);
      upd_valid      <= do_pop;
      redirect_valid <= mispredict;
      if (do_pop) begin
        upd_pc    <= h_pc;
        upd_hist  <= h_hist;
        upd_taken <= wb_actual_taken;
        br_count  <= (br_count == 16'hFFFF) ? br_count : (br_count + 16'd1);
      end
      if (mispredict) begin
        redirect_pc <= redirect_calc;
        mp_count    <= (mp_count == 16'hFFFF) ? mp_count : (mp_count + 16'd1);
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_br_resolve_queue.sv
// Directed bench for br_resolve_queue: stimulus pushes hand-computed responses into a
// scoreboard queue, a negedge monitor pops and compares whenever the DUT strobes.
module tb_br_resolve_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_push;
  logic [15:0] if_pc;
  logic        if_pred_taken;
  logic [15:0] if_pred_target;
  logic [2:0]  if_hist;
  logic        wb_resolve;
  logic        wb_actual_taken;
  logic [15:0] wb_actual_target;
  logic        full, empty, redirect_valid, upd_valid, upd_taken, err;
  logic [15:0] redirect_pc, upd_pc, br_count, mp_count;
  logic [2:0]  upd_hist;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] pc;
    logic [2:0]  hist;
    logic        taken;
    logic        redir;
    logic [15:0] rpc;
    logic [15:0] br;
    logic [15:0] mp;
  } exp_t;

  exp_t exp_q[$];

  br_resolve_queue dut (
    .clk(clk), .reset(reset),
    .if_push(if_push), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .if_hist(if_hist),
    .wb_resolve(wb_resolve), .wb_actual_taken(wb_actual_taken),
    .wb_actual_target(wb_actual_target),
    .full(full), .empty(empty), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist), .upd_taken(upd_taken),
    .br_count(br_count), .mp_count(mp_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if_push    = 1'b0;
    wb_resolve = 1'b0;
  endtask

  task automatic set_push(input logic [15:0] pc, input logic pt, input logic [15:0] tgt,
                          input logic [2:0] hist);
    if_push        = 1'b1;
    if_pc          = pc;
    if_pred_taken  = pt;
    if_pred_target = tgt;
    if_hist        = hist;
  endtask

  // Drive a resolve and record the hand-computed response it must produce
  task automatic set_resolve(input logic at, input logic [15:0] atgt,
                             input logic [15:0] e_pc, input logic [2:0] e_hist,
                             input logic e_redir, input logic [15:0] e_rpc,
                             input logic [15:0] e_br, input logic [15:0] e_mp);
    exp_t e;
    wb_resolve       = 1'b1;
    wb_actual_taken  = at;
    wb_actual_target = atgt;
    e.pc = e_pc; e.hist = e_hist; e.taken = at; e.redir = e_redir;
    e.rpc = e_rpc; e.br = e_br; e.mp = e_mp;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (upd_valid || redirect_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {30'd0, upd_valid, redirect_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("upd_valid", {31'd0, upd_valid}, 32'd1);
        chk("upd_pc", {16'd0, upd_pc}, {16'd0, e.pc});
        chk("upd_hist", {29'd0, upd_hist}, {29'd0, e.hist});
        chk("upd_taken", {31'd0, upd_taken}, {31'd0, e.taken});
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.redir});
        if (e.redir) chk("redirect_pc", {16'd0, redirect_pc}, {16'd0, e.rpc});
        chk("br_count", {16'd0, br_count}, {16'd0, e.br});
        chk("mp_count", {16'd0, mp_count}, {16'd0, e.mp});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; if_push = 1'b0; if_pc = 16'h0; if_pred_taken = 1'b0;
    if_pred_target = 16'h0; if_hist = 3'd0; wb_resolve = 1'b0;
    wb_actual_taken = 1'b0; wb_actual_target = 16'h0;
    tick(); tick();
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_br_count", {16'd0, br_count}, 32'd0);
    chk("rst_mp_count", {16'd0, mp_count}, 32'd0);
    reset = 1'b0;

    // correct taken prediction
    set_push(16'h3000, 1'b1, 16'h3010, 3'b101); tick();
    chk("t1_empty_after_push", {31'd0, empty}, 32'd0);
    set_resolve(1'b1, 16'h3010, 16'h3000, 3'd5, 1'b0, 16'h0, 16'd1, 16'd0); tick();
    chk("t1_empty_after_pop", {31'd0, empty}, 32'd1);

    // direction mispredict squashes younger entries, then recovery window
    set_push(16'h3000, 1'b1, 16'h3010, 3'd1); tick();
    set_push(16'h3004, 1'b0, 16'h0000, 3'd2); tick();
    set_push(16'h3008, 1'b0, 16'h0000, 3'd3); tick();
    set_resolve(1'b0, 16'h0000, 16'h3000, 3'd1, 1'b1, 16'h3002, 16'd2, 16'd1); tick();
    chk("t2_squash_empty", {31'd0, empty}, 32'd1);
    set_push(16'h5000, 1'b0, 16'h0000, 3'd0); tick();
    chk("t2_recover_push1_ignored", {31'd0, empty}, 32'd1);
    set_push(16'h5002, 1'b0, 16'h0000, 3'd0); tick();
    chk("t2_recover_push2_ignored", {31'd0, empty}, 32'd1);
    set_push(16'h5004, 1'b0, 16'h0000, 3'd4); tick();
    chk("t2_push3_accepted", {31'd0, empty}, 32'd0);
    chk("t2_err_clear", {31'd0, err}, 32'd0);
    set_resolve(1'b0, 16'h0000, 16'h5004, 3'd4, 1'b0, 16'h0, 16'd3, 16'd1); tick();

    // target mispredict
    set_push(16'h4000, 1'b1, 16'h4000, 3'd6); tick();
    set_resolve(1'b1, 16'h4100, 16'h4000, 3'd6, 1'b1, 16'h4100, 16'd4, 16'd2); tick();
    tick(); tick();

    // fill, overflow, push+pop at occupancy 3, drain
    set_push(16'h6000, 1'b0, 16'h0000, 3'd0); tick();
    set_push(16'h6002, 1'b0, 16'h0000, 3'd1); tick();
    set_push(16'h6004, 1'b0, 16'h0000, 3'd2); tick();
    set_push(16'h6006, 1'b0, 16'h0000, 3'd3); tick();
    chk("t4_full", {31'd0, full}, 32'd1);
    chk("t4_err_before_overflow", {31'd0, err}, 32'd0);
    set_push(16'h6008, 1'b0, 16'h0000, 3'd4); tick();
    chk("t4_overflow_err", {31'd0, err}, 32'd1);
    chk("t4_still_full", {31'd0, full}, 32'd1);
    set_resolve(1'b0, 16'h0000, 16'h6000, 3'd0, 1'b0, 16'h0, 16'd5, 16'd2); tick();
    chk("t4_not_full_at3", {31'd0, full}, 32'd0);
    set_push(16'h600A, 1'b0, 16'h0000, 3'd7);
    set_resolve(1'b0, 16'h0000, 16'h6002, 3'd1, 1'b0, 16'h0, 16'd6, 16'd2); tick();
    chk("t4_pushpop_full", {31'd0, full}, 32'd0);
    chk("t4_pushpop_empty", {31'd0, empty}, 32'd0);
    set_resolve(1'b0, 16'h0000, 16'h6004, 3'd2, 1'b0, 16'h0, 16'd7, 16'd2); tick();
    set_resolve(1'b0, 16'h0000, 16'h6006, 3'd3, 1'b0, 16'h0, 16'd8, 16'd2); tick();
    set_resolve(1'b0, 16'h0000, 16'h600A, 3'd7, 1'b0, 16'h0, 16'd9, 16'd2); tick();
    chk("t4_drained_empty", {31'd0, empty}, 32'd1);

    // resolve on empty after a fresh reset, then PC wrap on not-taken redirect
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_err_cleared", {31'd0, err}, 32'd0);
    wb_resolve = 1'b1; wb_actual_taken = 1'b1; wb_actual_target = 16'h1111; tick();
    chk("t5_empty_resolve_no_upd", {31'd0, upd_valid}, 32'd0);
    chk("t5_empty_resolve_err", {31'd0, err}, 32'd1);
    chk("t5_br_count_unchanged", {16'd0, br_count}, 32'd0);
    set_push(16'hFFFE, 1'b1, 16'h1234, 3'd2); tick();
    set_resolve(1'b0, 16'h0000, 16'hFFFE, 3'd2, 1'b1, 16'h0000, 16'd1, 16'd1); tick();

    // reset while recovering: recovery discarded, push accepted right after
    reset = 1'b1;
    set_push(16'h7777, 1'b0, 16'h0000, 3'd1); tick();
    chk("t6_rst_empty", {31'd0, empty}, 32'd1);
    chk("t6_rst_full", {31'd0, full}, 32'd0);
    chk("t6_rst_err", {31'd0, err}, 32'd0);
    chk("t6_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("t6_rst_redirect_pc", {16'd0, redirect_pc}, 32'd0);
    chk("t6_rst_upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("t6_rst_upd_pc", {16'd0, upd_pc}, 32'd0);
    chk("t6_rst_upd_hist", {29'd0, upd_hist}, 32'd0);
    chk("t6_rst_upd_taken", {31'd0, upd_taken}, 32'd0);
    chk("t6_rst_br_count", {16'd0, br_count}, 32'd0);
    chk("t6_rst_mp_count", {16'd0, mp_count}, 32'd0);
    reset = 1'b0;
    set_push(16'h7000, 1'b1, 16'h7100, 3'd5); tick();
    chk("t6_push_after_reset", {31'd0, empty}, 32'd0);
    set_resolve(1'b1, 16'h7100, 16'h7000, 3'd5, 1'b0, 16'h0, 16'd1, 16'd0); tick();
    tick(); tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
